echo_delay_sequencer: RTL and testbench

Sequences the shared delay-line memory for the echo effect. Per accepted audio sample it reads the delayed sample, mixes an attenuated copy into the dry input, and writes the mix back to a circular buffer. The mix is written back, so the echo feeds back and repeats.
Sits between the codec sample stream and the external delay-line RAM. Takes delay_time, delay_volume and disabled directly from echo_controller.

---
 rtl/echo_mem_if.sv | 23 ++
 rtl/echo_delay_sequencer.sv | 168 ++++++++++++++++
 tb/tb_echo_delay_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_mem_if.sv
// Delay-line RAM request/acknowledge bus between the echo sequencer (master)
// and the external delay-line memory (slave).
interface echo_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/echo_delay_sequencer.sv
// Echo delay-line sequencer: read delayed sample, mix attenuated echo into the
// dry sample, write the mix back. Define ECHO_CLEAR_EN to zero the RAM after reset.
//
// state   | meaning
// IDLE    | waiting for sample_valid
// RD      | reading delayed sample at wr_ptr - eff_delay
// MIX     | shift, add, saturate; disabled selects dry
// WR      | writing result at wr_ptr
// DONE    | sample_out_valid strobe, advance wr_ptr
// CLEAR   | post-reset zero sweep (ECHO_CLEAR_EN only)
module echo_delay_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic [31:0]              delay_time,
    input  logic [31:0]              delay_volume,
    input  logic                     disabled,
    echo_mem_if.master               mem,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_out_valid,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MIX,
        S_WR,
        S_DONE
`ifdef ECHO_CLEAR_EN
        , S_CLEAR
`endif
    } state_t;

`ifdef ECHO_CLEAR_EN
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    localparam logic [31:0] DMAX = 32'((64'd1 << ADDR_W) - 64'd1);
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                    state, state_n;
    logic [ADDR_W-1:0]         wr_ptr;
    logic [ADDR_W-1:0]         eff_delay;
    logic [2:0]                shift;
    logic signed [DATA_W-1:0]  dry;
    logic signed [DATA_W-1:0]  rdata_q;
    logic signed [DATA_W-1:0]  result;
`ifdef ECHO_CLEAR_EN
    logic [ADDR_W-1:0]         clr_addr;
`endif

    logic [ADDR_W-1:0]         eff_clamp;
    logic [2:0]                shift_clamp;
    logic signed [DATA_W-1:0]  echo;
    logic [DATA_W:0]           sum;
    logic signed [DATA_W-1:0]  mix_res;

    always_comb begin
        if (delay_time == 32'd0)
            eff_clamp = ADDR_W'(1);
        else if (delay_time > DMAX)
            eff_clamp = ADDR_W'(DMAX);
        else
            eff_clamp = delay_time[ADDR_W-1:0];

        if (delay_volume == 32'd0)
            shift_clamp = 3'd6;
        else if (delay_volume > 32'd6)
            shift_clamp = 3'd1;
        else
            shift_clamp = 3'd7 - delay_volume[2:0];
    end

    // Sum carries one guard bit; disagreeing top bits mean overflow.
    always_comb begin
        echo = rdata_q >>> shift;
        sum  = {dry[DATA_W-1], dry} + {echo[DATA_W-1], echo};
        if (sum[DATA_W] != sum[DATA_W-1])
            mix_res = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        else
            mix_res = sum[DATA_W-1:0];
        if (disabled)
            mix_res = dry;
    end

    always_comb begin
        state_n          = state;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr     = '0;
        mem.mem_wdata    = '0;
        sample_out_valid = 1'b0;
        busy             = (state != S_IDLE);
        overrun          = sample_valid && (state != S_IDLE);
        case (state)
            S_IDLE: if (sample_valid) state_n = S_RD;
            S_RD: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = wr_ptr - eff_delay;
                if (mem.mem_ack) state_n = S_MIX;
            end
            S_MIX: state_n = S_WR;
            S_WR: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = wr_ptr;
                mem.mem_wdata = result;
                if (mem.mem_ack) state_n = S_DONE;
            end
            S_DONE: begin
                sample_out_valid = 1'b1;
                state_n          = S_IDLE;
            end
`ifdef ECHO_CLEAR_EN
            S_CLEAR: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = 1'b1;
                mem.mem_addr = clr_addr;
                if (mem.mem_ack && (clr_addr == {ADDR_W{1'b1}})) state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RST_STATE;
            wr_ptr     <= '0;
            eff_delay  <= '0;
            shift      <= '0;
            dry        <= '0;
            rdata_q    <= '0;
            result     <= '0;
            sample_out <= '0;
`ifdef ECHO_CLEAR_EN
            clr_addr   <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (sample_valid) begin
                    dry       <= sample_in;
                    eff_delay <= eff_clamp;
                    shift     <= shift_clamp;
                end
                S_RD:   if (mem.mem_ack) rdata_q <= mem.mem_rdata;
                S_MIX:  result <= mix_res;
                S_WR:   if (mem.mem_ack) sample_out <= result;
                S_DONE: wr_ptr <= wr_ptr + 1'b1;
`ifdef ECHO_CLEAR_EN
                S_CLEAR: if (mem.mem_ack) clr_addr <= clr_addr + 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_sequencer.sv
// Scoreboard bench for echo_delay_sequencer with a behavioural delay-line RAM
// and an independent mix model; ack latency is programmable.
module tb_echo_delay_sequencer;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] sample_in = '0;
    logic [31:0]          delay_time = 32'd3;
    logic [31:0]          delay_volume = 32'd6;
    logic                 disabled = 1'b0;
    logic signed [DW-1:0] sample_out;
    logic                 sample_out_valid, busy, overrun;

    echo_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    echo_delay_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .delay_time       (delay_time),
        .delay_volume     (delay_volume),
        .disabled         (disabled),
        .mem              (mem),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ack_wait = 0;
    int wcnt = 0;
    longint first_req;
    int ref_ptr = 0;
    logic signed [DW-1:0] tb_mem [DEPTH];
    logic signed [DW-1:0] ref_mem [DEPTH];
    int q_out[$], q_lat[$], q_acc[$], q_rd[$], q_wa[$], q_wd[$];

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    always @(posedge CLK) cyc++;

    // RAM model: ack after ack_wait extra request cycles; checks request stability.
    initial begin
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
    end
    always @(negedge CLK) begin
        if (RST || !mem.mem_req) begin
            mem.mem_ack = 1'b0;
            wcnt = 0;
        end else begin
            if (wcnt == 0)
                first_req = {mem.mem_we, mem.mem_addr, mem.mem_wdata};
            else
                chk("req_stable", {mem.mem_we, mem.mem_addr, mem.mem_wdata}, first_req);
            if (wcnt >= ack_wait) begin
                mem.mem_ack = 1'b1;
                wcnt = 0;
                if (mem.mem_we) begin
                    if (q_wa.size() == 0) chk("wr_extra", 1, 0);
                    else begin
                        chk("wr_addr", mem.mem_addr, q_wa.pop_front());
                        chk("wr_data", $signed(mem.mem_wdata), q_wd.pop_front());
                    end
                    tb_mem[mem.mem_addr] = mem.mem_wdata;
                end else begin
                    if (q_rd.size() == 0) chk("rd_extra", 1, 0);
                    else chk("rd_addr", mem.mem_addr, q_rd.pop_front());
                    mem.mem_rdata = tb_mem[mem.mem_addr];
                end
            end else begin
                mem.mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && sample_out_valid) begin
            if (q_out.size() == 0) chk("out_extra", 1, 0);
            else begin
                chk("sample_out", sample_out, q_out.pop_front());
                chk("latency", cyc - q_acc.pop_front(), q_lat.pop_front());
            end
        end
    end

    task automatic ref_push(input logic signed [DW-1:0] s);
        int eff, vol, ra, echo, sum, res;
        eff = (delay_time == 0) ? 1 : (delay_time > DEPTH - 1) ? DEPTH - 1 : int'(delay_time);
        vol = (delay_volume == 0) ? 1 : (delay_volume > 6) ? 6 : int'(delay_volume);
        ra = (ref_ptr - eff) & (DEPTH - 1);
        echo = int'(ref_mem[ra]) >>> (7 - vol);
        sum = int'(s) + echo;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        res = disabled ? int'(s) : sum;
        q_rd.push_back(ra);
        q_wa.push_back(ref_ptr);
        q_wd.push_back(res);
        q_out.push_back(res);
        q_lat.push_back(3 + 2 * ack_wait);
        ref_mem[ref_ptr] = DW'(res);
        ref_ptr = (ref_ptr + 1) & (DEPTH - 1);
    endtask

    task automatic send(input logic signed [DW-1:0] s, input bit drop);
        @(posedge CLK);
        #1;
        sample_in = s;
        sample_valid = 1'b1;
        if (!drop) ref_push(s);
        @(negedge CLK);
        chk("overrun", overrun, drop);
        @(posedge CLK);
        #1;
        if (!drop) q_acc.push_back(cyc);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (!busy && q_out.size() == 0) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic run(input logic signed [DW-1:0] s);
        send(s, 1'b0);
        wait_idle();
    endtask

    // RST held for one edge; checks the state right after that edge.
    task automatic apply_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
`ifdef ECHO_CLEAR_EN
        chk("rst_busy", busy, 1);
        chk("rst_req", mem.mem_req, 1);
        chk("rst_clr_addr", mem.mem_addr, 0);
`else
        chk("rst_busy", busy, 0);
        chk("rst_req", mem.mem_req, 0);
`endif
        chk("rst_out_valid", sample_out_valid, 0);
        chk("rst_overrun", overrun, 0);
        q_out.delete(); q_lat.delete(); q_acc.delete();
        q_rd.delete(); q_wa.delete(); q_wd.delete();
        ref_ptr = 0;
`ifdef ECHO_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            q_wa.push_back(i);
            q_wd.push_back(0);
            ref_mem[i] = '0;
        end
`else
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = tb_mem[i];
`endif
        RST = 1'b0;
        wait_idle();
        chk("clear_writes_left", q_wa.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i] = '0;
            ref_mem[i] = '0;
        end
        apply_reset();
        chk("rst_sample_out", sample_out, 0);

        // Echo train: 1000 then zeros, delay 3, volume 6
        begin
            int exp_train [7] = '{1000, 0, 0, 500, 0, 0, 250};
            int t [7] = '{1000, 0, 0, 0, 0, 0, 0};
            for (int i = 0; i < 7; i++) begin
                send(DW'(t[i]), 1'b0);
                wait_idle();
                chk("train", sample_out, exp_train[i]);
            end
        end

        // Wrap across the buffer with delay 2
        delay_time = 32'd2;
        for (int i = 0; i < 20; i++) run(DW'(i * 37 - 300));

        // Saturation, positive and negative
        delay_time = 32'd1;
        disabled = 1'b1; run(16'sd32767);
        disabled = 1'b0; run(16'sd32000);
        chk("sat_pos", sample_out, 32767);
        disabled = 1'b1; run(-16'sd32768);
        disabled = 1'b0; run(-16'sd32000);
        chk("sat_neg", sample_out, -32768);

        // Clamping of delay_time and delay_volume
        delay_time = 32'd0;      run(16'sd1200);
        delay_time = 32'd100000; run(-16'sd900);
        delay_time = 32'd5;
        delay_volume = 32'd0;    run(16'sd640);
        delay_volume = 32'd9;    run(-16'sd640);

        // Bypass still writes memory
        disabled = 1'b1; delay_volume = 32'd6;
        run(16'sd1234);
        chk("bypass_out", sample_out, 1234);
        disabled = 1'b0;

        // Slow ack, with a sample arriving during RD
        ack_wait = 5;
        send(16'sd4321, 1'b0);
        send(16'sd55, 1'b1);
        wait_idle();
        ack_wait = 0;

        // A few random samples and settings
        for (int i = 0; i < 8; i++) begin
            delay_time = $urandom_range(1, 15);
            delay_volume = $urandom_range(1, 6);
            run(DW'($urandom));
        end

        // Reset while WR is waiting for ack
        ack_wait = 3;
        send(16'sd777, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge CLK);
                #1;
                if (mem.mem_req && mem.mem_we) seen = 1'b1;
            end
            chk("reached_wr", seen, 1);
        end
        ack_wait = 0;
        apply_reset();
        delay_time = 32'd1;
        run(16'sd100);
        run(16'sd200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
